eproc_in_align10b: RTL

// - Parametrised successor of the 2-bit EPROC_IN input stage: deserialises an EWIDTH-bit e-link stream
//   (2/4/8 bits per bitCLK) into 10-bit words.
// - Finds K28.5 comma alignment, confirms it with a lock FSM, and flags comma words.
// - Sits between the e-link pins and the 8b10b decoder.
// - Adds per-mode width, lock/loss hysteresis and a realignment counter, none of which the fixed 2-bit stage has.

---
 rtl/eproc_in_align10b.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/eproc_in_align10b.sv
// E-link input stage: deserialises an EWIDTH-bit stream into K28.5-aligned 10-bit words.
// The HUNT/VERIFY/LOCKED FSM adds lock/loss hysteresis and a saturating realignment count.
module eproc_in_align10b #(
    parameter int EWIDTH      = 2,
    parameter int LOCK_COMMAS = 4,
    parameter int LOSS_COMMAS = 3,
    parameter int MAX_GAP     = 255
) (
    input  logic              bitCLK,
    input  logic              rst,
    input  logic [EWIDTH-1:0] DATA_IN,
    input  logic              swap_inputbits,
    input  logic              thCR_REVERSE_10B,
    output logic [9:0]        DATA_OUT,
    output logic              DATA_RDY,
    output logic              IS_COMMA,
    output logic              LOCKED,
    output logic [3:0]        align_offset,
    output logic [7:0]        realign_cnt
);

    // state     | meaning
    // ST_HUNT   | searching every bit offset for a K28.5 comma
    // ST_VERIFY | offset latched, counting aligned commas toward lock
    // ST_LOCKED | aligned; counting consecutive misaligned commas toward loss
    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

    localparam int         WW       = 9 + EWIDTH;
    localparam logic [9:0] COMMA_N  = 10'h0FA;
    localparam logic [9:0] COMMA_P  = 10'h305;
    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COMMAS);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COMMAS);
    localparam logic [7:0] GAP_MAX  = 8'(MAX_GAP);
    localparam logic [4:0] EW5      = 5'(EWIDTH);

    state_t     state_q, state_d;
    logic [8:0] hist_q, hist_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [3:0] off_q, off_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] miss_q, miss_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] realign_q, realign_d;
    logic [9:0] data_q, data_d;
    logic       rdy_q, rdy_d;
    logic       comma_q, comma_d;
    logic       locked_q, locked_d;

    logic [EWIDTH-1:0] chunk;
    logic [WW-1:0]     win;
    logic [9:0]        wnd [EWIDTH];
    logic [3:0]        wnd_off [EWIDTH];
    logic [EWIDTH-1:0] wnd_comma;
    logic [4:0]        idx_sum;

    logic       hunt_hit;
    logic [9:0] hunt_word;
    logic [3:0] hunt_off;
    logic       emit_valid;
    logic [9:0] emit_word;
    logic       emit_comma;
    logic       mis_comma;

    function automatic logic [9:0] out_order(input logic [9:0] w, input logic rev);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = w[9-i];
        end
        return rev ? r : w;
    endfunction

    // chunk[EWIDTH-1] is always the earliest bit; win runs oldest (MSB) to newest (LSB)
    always_comb begin
        chunk = DATA_IN;
        if (swap_inputbits) begin
            for (int i = 0; i < EWIDTH; i++) begin
                chunk[EWIDTH-1-i] = DATA_IN[i];
            end
        end
    end

    assign win     = {hist_q, chunk};
    assign hist_d  = win[8:0];
    assign idx_sum = {1'b0, bit_idx_q} + EW5;
    assign bit_idx_d = (idx_sum >= 5'd10) ? 4'(idx_sum - 5'd10) : idx_sum[3:0];

    // window j ends at the j-th new bit; its first bit sits at stream index (bit_idx + j + 1) mod 10
    for (genvar j = 0; j < EWIDTH; j++) begin : g_wnd
        logic [4:0] sum;
        assign wnd[j]       = win[EWIDTH-1-j +: 10];
        assign sum          = {1'b0, bit_idx_q} + 5'(j + 1);
        assign wnd_off[j]   = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
        assign wnd_comma[j] = (wnd[j] == COMMA_N) || (wnd[j] == COMMA_P);
    end

    always_comb begin
        hunt_hit   = 1'b0;
        hunt_word  = '0;
        hunt_off   = '0;
        emit_valid = 1'b0;
        emit_word  = '0;
        emit_comma = 1'b0;
        mis_comma  = 1'b0;
        for (int j = 0; j < EWIDTH; j++) begin
            if (wnd_comma[j] && !hunt_hit) begin
                hunt_hit  = 1'b1;
                hunt_word = wnd[j];
                hunt_off  = wnd_off[j];
            end
            if (wnd_off[j] == off_q) begin
                emit_valid = 1'b1;
                emit_word  = wnd[j];
                emit_comma = wnd_comma[j];
            end else if (wnd_comma[j]) begin
                mis_comma = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        gap_d     = gap_q;
        realign_d = realign_q;
        data_d    = data_q;
        rdy_d     = 1'b0;
        comma_d   = 1'b0;
        locked_d  = locked_q;
        case (state_q)
            ST_HUNT: begin
                if (hunt_hit) begin
                    off_d   = hunt_off;
                    data_d  = out_order(hunt_word, thCR_REVERSE_10B);
                    rdy_d   = 1'b1;
                    comma_d = 1'b1;
                    cnt_d   = 4'd1;
                    gap_d   = '0;
                    miss_d  = '0;
                    if (LOCK_CNT == 4'd1) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                if (emit_valid && emit_comma) begin
                    data_d  = out_order(emit_word, thCR_REVERSE_10B);
                    rdy_d   = 1'b1;
                    comma_d = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    gap_d   = '0;
                    if (cnt_q + 4'd1 == LOCK_CNT) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        miss_d   = '0;
                    end
                end else if (mis_comma) begin
                    state_d = ST_HUNT;
                end else if (emit_valid) begin
                    data_d = out_order(emit_word, thCR_REVERSE_10B);
                    rdy_d  = 1'b1;
                    if (gap_q + 8'd1 == GAP_MAX) begin
                        state_d = ST_HUNT;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (emit_valid) begin
                    data_d  = out_order(emit_word, thCR_REVERSE_10B);
                    rdy_d   = 1'b1;
                    comma_d = emit_comma;
                end
                // an aligned comma outranks any misaligned one seen in the same cycle
                if (emit_valid && emit_comma) begin
                    miss_d = '0;
                end else if (mis_comma) begin
                    if (miss_q + 4'd1 == LOSS_CNT) begin
                        state_d   = ST_HUNT;
                        locked_d  = 1'b0;
                        miss_d    = '0;
                        realign_d = (realign_q == 8'hFF) ? realign_q : realign_q + 8'd1;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d  = ST_HUNT;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge bitCLK or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HUNT;
            hist_q    <= '0;
            bit_idx_q <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            miss_q    <= '0;
            gap_q     <= '0;
            realign_q <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            comma_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            bit_idx_q <= bit_idx_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            gap_q     <= gap_d;
            realign_q <= realign_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            comma_q   <= comma_d;
            locked_q  <= locked_d;
        end
    end

    assign DATA_OUT     = data_q;
    assign DATA_RDY     = rdy_q;
    assign IS_COMMA     = comma_q;
    assign LOCKED       = locked_q;
    assign align_offset = off_q;
    assign realign_cnt  = realign_q;

endmodule
